elink_tx_frame_packer: RTL

//  Sits directly upstream of the elink transmit buffer/mux. Takes one parallel

---
 rtl/elink_tx_frame_packer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/elink_tx_frame_packer.sv
// ============================================================================
// elink_tx_frame_packer : packs one parallel message into SOP/data/[CRC]/EOP
// elink words, followed by idle commas. Define ELINK_TX_CRC_EN to add the CRC-8 word.
// Revision 1.0
// ============================================================================
`default_nettype none

module elink_tx_frame_packer #(
  parameter int         MSG_BYTES = 10,
  parameter int         GAP_WORDS = 2,
  parameter logic [7:0] SOP_CHAR  = 8'h3C,
  parameter logic [7:0] EOP_CHAR  = 8'hDC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*MSG_BYTES-1:0] msg_in,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic                   word_tick,
  input  logic [7:0]             Kchar_comma,
  output logic [9:0]             data_tra_out,
  output logic                   buffer_en,
  output logic                   frame_done
);

  localparam int IDX_W = $clog2(MSG_BYTES);
  localparam int GAP_W = $clog2(GAP_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOP  = 3'd1,
    S_DATA = 3'd2,
`ifdef ELINK_TX_CRC_EN
    S_CRC  = 3'd3,
`endif
    S_EOP  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t                 state;
  logic [8*MSG_BYTES-1:0] msg;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [9:0]             comma_word;
  logic [7:0]             cur_byte;
  logic [7:0]             next_byte;

  // Latched message shifts left by one byte per consumed data word,
  // so the byte on the wire is always the top byte.
  assign comma_word = {2'b11, Kchar_comma};
  assign cur_byte   = msg[8*MSG_BYTES-1 -: 8];
  assign next_byte  = msg[8*MSG_BYTES-9 -: 8];

`ifdef ELINK_TX_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      msg          <= '0;
      idx          <= '0;
      gap_cnt      <= '0;
      msg_ready    <= 1'b0;
      data_tra_out <= comma_word;
      buffer_en    <= 1'b0;
      frame_done   <= 1'b0;
`ifdef ELINK_TX_CRC_EN
      crc          <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (msg_ready && msg_valid) begin
            msg          <= msg_in;
            idx          <= '0;
            state        <= S_SOP;
            msg_ready    <= 1'b0;
            data_tra_out <= {2'b10, SOP_CHAR};
            buffer_en    <= 1'b1;
`ifdef ELINK_TX_CRC_EN
            crc          <= 8'h00;
`endif
          end else begin
            msg_ready    <= 1'b1;
            data_tra_out <= comma_word;
          end
        end
        S_SOP: begin
          if (word_tick) begin
            state        <= S_DATA;
            data_tra_out <= {2'b00, cur_byte};
          end
        end
        S_DATA: begin
          if (word_tick) begin
`ifdef ELINK_TX_CRC_EN
            crc <= crc8_next(crc, cur_byte);
`endif
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef ELINK_TX_CRC_EN
              state        <= S_CRC;
              data_tra_out <= {2'b00, crc8_next(crc, cur_byte)};
`else
              state        <= S_EOP;
              data_tra_out <= {2'b01, EOP_CHAR};
`endif
            end else begin
              idx          <= idx + IDX_W'(1);
              msg          <= msg << 8;
              data_tra_out <= {2'b00, next_byte};
            end
          end
        end
`ifdef ELINK_TX_CRC_EN
        S_CRC: begin
          if (word_tick) begin
            state        <= S_EOP;
            data_tra_out <= {2'b01, EOP_CHAR};
          end
        end
`endif
        S_EOP: begin
          if (word_tick) begin
            state        <= S_GAP;
            gap_cnt      <= '0;
            data_tra_out <= comma_word;
            buffer_en    <= 1'b0;
            frame_done   <= 1'b1;
          end
        end
        S_GAP: begin
          data_tra_out <= comma_word;
          if (word_tick) begin
            if (gap_cnt == LAST_GAP) begin
              state     <= S_IDLE;
              gap_cnt   <= '0;
              msg_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          msg_ready    <= 1'b0;
          data_tra_out <= comma_word;
          buffer_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
